axis_mem_arbiter: RTL and testbench
===================================

Name: axis_mem_arbiter

Overview:
- Round-robin arbiter that shares one axi_stream_memory instance between NUM_REQ AXI-Stream requesters.
- Each requester sends request packets: CMD, ADDR, then DATA for writes only. The last word of every packet carries tlast.
- The block grants one requester, forwards that requester's whole packet to the memory and waits for the single-beat response. It then returns the response to the same requester and re-arbitrates.
- Exactly one transaction is outstanding at a time. The memory does not echo tdest, so the arbiter itself tracks which requester owns the response.

Parameters:
- DATA_WIDTH, 64, width of request/response words.
- NUM_REQ, 4, number of requesters; legal range 2..4, because tdest is 2 bits.
- CNT_WIDTH, 16, width of the completed-transaction counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- req_s_axis_tdata  in  NUM_REQ*DATA_WIDTH  request data, packed; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_s_axis_tvalid  in  NUM_REQ  per-requester valid.
- req_s_axis_tready  out  NUM_REQ  per-requester ready.
- req_s_axis_tlast  in  NUM_REQ  per-requester end of packet.
- mem_m_axis_tdata  out  DATA_WIDTH  request word to memory.
- mem_m_axis_tvalid  out  1  valid to memory.
- mem_m_axis_tready  in  1  ready from memory.
- mem_m_axis_tlast  out  1  tlast to memory.
- mem_m_axis_tdest  out  2  index of the granted requester.
- mem_s_axis_tdata  in  DATA_WIDTH  response word from memory.
- mem_s_axis_tvalid  in  1  response valid.
- mem_s_axis_tready  out  1  response ready.
- mem_s_axis_tlast  in  1  response tlast.
- rsp_m_axis_tdata  out  DATA_WIDTH  response data, broadcast to all requesters.
- rsp_m_axis_tvalid  out  NUM_REQ  per-requester response valid.
- rsp_m_axis_tready  in  NUM_REQ  per-requester response ready.
- rsp_m_axis_tlast  out  1  response tlast.
- rsp_m_axis_tdest  out  2  requester index of the response.
- busy  out  1  high whenever the state is not ARB.
- grant_id  out  2  current or most recent grant.
- txn_count  out  CNT_WIDTH  number of completed transactions.

Behaviour:
- Reset (async assert, sync release):
  - State is ARB, grant_id=0, rr pointer=0, txn_count=0.
  - All tvalid/tready outputs are 0 and busy=0.
- State ARB:
  - Scan requesters starting at index rr pointer, wrapping modulo NUM_REQ, for the first with req_s_axis_tvalid=1.
  - If one is found: register grant_id, set rr pointer = grant+1 mod NUM_REQ, go to FWD on the next edge.
  - Requester tready stays 0 in ARB, so no data is consumed while arbitrating.
- State FWD (combinational pass-through from the granted requester g):
  - mem_m_axis_tdata/tvalid/tlast come from g.
  - req_s_axis_tready[g] = mem_m_axis_tready; tready for every other requester is 0.
  - mem_m_axis_tdest = g.
  - A stall (tvalid of g dropping mid-packet) holds FWD indefinitely; the grant is never revoked mid-packet.
  - When a beat with tlast is accepted, go to RSP.
- State RSP:
  - mem_m_axis_tvalid=0.
  - rsp_m_axis_tvalid[g] = mem_s_axis_tvalid; all other bits are 0.
  - mem_s_axis_tready = rsp_m_axis_tready[g].
  - rsp_m_axis_tdata and rsp_m_axis_tlast pass through from memory; rsp_m_axis_tdest = g.
  - On the response handshake: txn_count += 1, wrapping modulo 2^CNT_WIDTH, then go to ARB.
- mem_s_axis_tready is 0 outside RSP. A stray memory response is held off, never dropped or misrouted.
- Latency:
  - A request asserted while ARB is idle is granted at the next edge.
  - Its first beat can transfer in cycle 1.
  - After the response handshake, the minimum gap to the next grant is one cycle, spent in ARB.
- Fairness: a requester that is continuously valid waits at most NUM_REQ-1 transactions.
- Simultaneous events:
  - A requester deasserting valid in the same cycle ARB samples it is still granted if it was sampled high.
  - The requester must then complete its packet, per AXI-Stream rules.
- Reset mid-packet or mid-response:
  - Everything is aborted immediately and the block returns to ARB with rr pointer=0.
  - The memory must be reset together with the arbiter.

Test Plan:
- Requester 1 sends read of addr 0x05 (0x0, tlast=0; 0x05, tlast=1); memory holds 0xABCD.
  - Required: mem_m_axis_tdest=1 on both beats.
  - Required: rsp_m_axis_tvalid=4'b0010 with data 0xABCD; txn_count=1.
- Requester 2 writes 0x1234 to addr 0x10, then requester 0 reads addr 0x10.
  - Required: requester 2 receives ack 0x1; requester 0 receives 0x1234.
- All four requesters hold valid continuously, each issuing 3 reads.
  - Required: grant order is 0,1,2,3,0,1,2,3,0,1,2,3 and txn_count=12.
  - Required: no tready is seen on any non-granted requester.
- Requester 3 holds rsp_m_axis_tready=0 for 10 cycles while requester 0 is valid.
  - Required: mem_s_axis_tready=0 and the response data is held stable.
  - Required: requester 0 is not granted until the response handshake completes.
- Granted requester drops tvalid for 5 cycles between the CMD and ADDR beats while requester 2 is valid.
  - Required: the grant is held, and the packet completes intact.
- Assert aresetn=0 mid-FWD of a write.
  - Required: all valid/ready outputs go 0 asynchronously; busy=0, txn_count=0.
  - Required: after release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/axis_mem_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream memory between NUM_REQ requesters, one transaction at a time.
// Grant lands one edge after a request is seen in ARB. Beats and responses pass through combinationally, so both sides see the other side's backpressure directly.
module axis_mem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_s_axis_tdata,
  input  logic [NUM_REQ-1:0]            req_s_axis_tvalid,
  output logic [NUM_REQ-1:0]            req_s_axis_tready,
  input  logic [NUM_REQ-1:0]            req_s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         mem_m_axis_tdata,
  output logic                          mem_m_axis_tvalid,
  input  logic                          mem_m_axis_tready,
  output logic                          mem_m_axis_tlast,
  output logic [1:0]                    mem_m_axis_tdest,
  input  logic [DATA_WIDTH-1:0]         mem_s_axis_tdata,
  input  logic                          mem_s_axis_tvalid,
  output logic                          mem_s_axis_tready,
  input  logic                          mem_s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         rsp_m_axis_tdata,
  output logic [NUM_REQ-1:0]            rsp_m_axis_tvalid,
  input  logic [NUM_REQ-1:0]            rsp_m_axis_tready,
  output logic                          rsp_m_axis_tlast,
  output logic [1:0]                    rsp_m_axis_tdest,
  output logic                          busy,
  output logic [1:0]                    grant_id,
  output logic [CNT_WIDTH-1:0]          txn_count
);

  typedef enum logic [1:0] {ARB, FWD, RSP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic [1:0]           rr_q, rr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Per-requester vectors padded to the 2-bit index space so grant_q indexes them directly.
  logic [3:0] req_vld4, req_lst4, rsp_rdy4, req_rdy4, rsp_vld4;
  assign req_vld4 = 4'(req_s_axis_tvalid);
  assign req_lst4 = 4'(req_s_axis_tlast);
  assign rsp_rdy4 = 4'(rsp_m_axis_tready);

  logic       pick_found;
  logic [1:0] pick_idx;

  always_comb begin
    int t;
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      t = int'(rr_q) + k;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      if (req_vld4[t[1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = t[1:0];
      end
    end
  end

  always_comb begin
    mem_m_axis_tdata  = req_s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    mem_m_axis_tlast  = req_lst4[grant_q];
    mem_m_axis_tdest  = grant_q;
    mem_m_axis_tvalid = 1'b0;
    req_rdy4          = 4'b0000;
    mem_s_axis_tready = 1'b0;
    rsp_vld4          = 4'b0000;
    rsp_m_axis_tdata  = mem_s_axis_tdata;
    rsp_m_axis_tlast  = mem_s_axis_tlast;
    rsp_m_axis_tdest  = grant_q;
    case (state_q)
      FWD: begin
        mem_m_axis_tvalid = req_vld4[grant_q];
        req_rdy4[grant_q] = mem_m_axis_tready;
      end
      RSP: begin
        rsp_vld4[grant_q] = mem_s_axis_tvalid;
        mem_s_axis_tready = rsp_rdy4[grant_q];
      end
      default: ;
    endcase
  end

  assign req_s_axis_tready = req_rdy4[NUM_REQ-1:0];
  assign rsp_m_axis_tvalid = rsp_vld4[NUM_REQ-1:0];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB: if (pick_found) begin
        grant_d = pick_idx;
        rr_d    = (int'(pick_idx) == NUM_REQ - 1) ? 2'd0 : pick_idx + 2'd1;
        state_d = FWD;
      end
      FWD: if (mem_m_axis_tvalid && mem_m_axis_tready && mem_m_axis_tlast) state_d = RSP;
      RSP: if (mem_s_axis_tvalid && mem_s_axis_tready) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ARB;
      grant_q <= 2'd0;
      rr_q    <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != ARB);
  assign grant_id  = grant_q;
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_axis_mem_arbiter.sv
// Randomized scoreboard bench for axis_mem_arbiter with a behavioural memory and request-level reference model.
module tb_axis_mem_arbiter;
  localparam int DW = 64;
  localparam int NR = 4;
  localparam int CW = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [NR*DW-1:0] req_tdata;
  logic [NR-1:0]    req_tvalid, req_tready, req_tlast;
  logic [DW-1:0]    rq_dat [NR];
  logic             rq_vld [NR];
  logic             rq_lst [NR];
  logic [DW-1:0]    mm_tdata, ms_tdata, rsp_tdata;
  logic             mm_tvalid, mm_tready, mm_tlast;
  logic             ms_tvalid, ms_tready, ms_tlast;
  logic [1:0]       mm_tdest, rsp_tdest, grant_id;
  logic [NR-1:0]    rsp_tvalid, rsp_rdy;
  logic             rsp_tlast, busy;
  logic [CW-1:0]    txn_count;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_tdata[i*DW +: DW] = rq_dat[i];
      req_tvalid[i]         = rq_vld[i];
      req_tlast[i]          = rq_lst[i];
    end
  end

  axis_mem_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_s_axis_tdata(req_tdata), .req_s_axis_tvalid(req_tvalid),
    .req_s_axis_tready(req_tready), .req_s_axis_tlast(req_tlast),
    .mem_m_axis_tdata(mm_tdata), .mem_m_axis_tvalid(mm_tvalid), .mem_m_axis_tready(mm_tready),
    .mem_m_axis_tlast(mm_tlast), .mem_m_axis_tdest(mm_tdest),
    .mem_s_axis_tdata(ms_tdata), .mem_s_axis_tvalid(ms_tvalid), .mem_s_axis_tready(ms_tready),
    .mem_s_axis_tlast(ms_tlast),
    .rsp_m_axis_tdata(rsp_tdata), .rsp_m_axis_tvalid(rsp_tvalid), .rsp_m_axis_tready(rsp_rdy),
    .rsp_m_axis_tlast(rsp_tlast), .rsp_m_axis_tdest(rsp_tdest),
    .busy(busy), .grant_id(grant_id), .txn_count(txn_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pkts_done_exp = 0;
  logic [63:0] ref_mem [256];
  logic [63:0] tb_mem  [256];
  logic [63:0] exp_q   [NR][$];
  int          grant_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic sync();
    @(posedge aclk);
    #1;
  endtask

  // One request packet; the expected response comes from the reference memory at issue time.
  task automatic send(input int i, input bit wr, input logic [7:0] addr,
                      input logic [63:0] data, input int stall);
    logic [63:0] w[$];
    logic [3:0]  others;
    bit hs;
    int t;
    w.push_back(wr ? 64'd1 : 64'd0);
    w.push_back({56'd0, addr});
    if (wr) w.push_back(data);
    if (wr) begin
      ref_mem[addr] = data;
      exp_q[i].push_back(64'd1);
    end else begin
      exp_q[i].push_back(ref_mem[addr]);
    end
    pkts_done_exp++;
    foreach (w[k]) begin
      rq_dat[i] = w[k];
      rq_lst[i] = (k == w.size() - 1);
      rq_vld[i] = 1'b1;
      hs = 1'b0;
      t  = 0;
      while (!hs && t < 2000) begin
        @(negedge aclk);
        hs = req_tready[i];
        if (hs) check("beat_tdest", 64'(mm_tdest), 64'(i));
        @(posedge aclk);
        #1;
        t++;
      end
      if (!hs) fail("beat_accept");
      rq_vld[i] = 1'b0;
      if (k == 0 && stall > 0) begin
        repeat (stall) begin
          @(negedge aclk);
          check("stall_grant_held", 64'(grant_id), 64'(i));
          others    = req_tready;
          others[i] = 1'b0;
          check("stall_no_other_tready", 64'(others), 64'd0);
          @(posedge aclk);
          #1;
        end
      end
    end
  endtask

  task automatic send_reads(input int r, input int n);
    for (int k = 0; k < n; k++) send(r, 1'b0, 8'(8'h40 + r*4 + k), 64'd0, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && t < 3000) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 3000) fail("idle_wait");
    repeat (3) @(negedge aclk);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    pkts_done_exp = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    sync();
  endtask

  // Behavioural memory: CMD 1 = write (ack 1), else read; responds 0-2 cycles after tlast.
  initial begin
    logic [63:0] beats[$];
    logic [63:0] rsp_val;
    bit pending, bhs, rhs;
    int dly;
    pending = 1'b0; dly = 0; rsp_val = '0;
    mm_tready = 1'b0; ms_tvalid = 1'b0; ms_tdata = '0; ms_tlast = 1'b1;
    forever begin
      @(negedge aclk);
      bhs = aresetn && mm_tvalid && mm_tready;
      rhs = aresetn && ms_tvalid && ms_tready;
      if (bhs) begin
        beats.push_back(mm_tdata);
        if (mm_tlast) begin
          grant_log.push_back(int'(mm_tdest));
          if (beats.size() >= 3 && beats[0] == 64'd1) begin
            tb_mem[beats[1][7:0]] = beats[2];
            rsp_val = 64'd1;
          end else begin
            rsp_val = tb_mem[beats[1][7:0]];
          end
          beats.delete();
          pending = 1'b1;
          dly = $urandom_range(0, 2);
        end
      end
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        beats.delete();
        pending   = 1'b0;
        ms_tvalid = 1'b0;
        mm_tready = 1'b0;
      end else begin
        mm_tready = ($urandom_range(0, 3) != 0);
        if (rhs) ms_tvalid = 1'b0;
        if (pending && !ms_tvalid) begin
          if (dly == 0) begin
            ms_tvalid = 1'b1;
            ms_tdata  = rsp_val;
            pending   = 1'b0;
          end else dly--;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a requester completes a response handshake.
  initial begin
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (req_tready != '0) check("tready_onehot", 64'($countones(req_tready)), 64'd1);
        if (rsp_tvalid != '0) check("rsp_vld_onehot", 64'($countones(rsp_tvalid)), 64'd1);
        for (int i = 0; i < NR; i++) begin
          if (rsp_tvalid[i] && rsp_rdy[i]) begin
            check("rsp_tdest", 64'(rsp_tdest), 64'(i));
            check("rsp_tlast", 64'(rsp_tlast), 64'd1);
            if (exp_q[i].size() == 0) begin
              n_checks++;
              $display("FAIL rsp_unexpected: requester %0d got 0x%0h, expected no response", i, rsp_tdata);
            end else begin
              check("rsp_data", rsp_tdata, exp_q[i].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int g0, t;
    bit hs;
    logic [63:0] v;
    for (int i = 0; i < NR; i++) begin
      rq_dat[i] = '0; rq_vld[i] = 1'b0; rq_lst[i] = 1'b0;
    end
    rsp_rdy = '1;
    for (int a = 0; a < 256; a++) begin
      v = {$urandom, $urandom};
      ref_mem[a] = v;
      tb_mem[a]  = v;
    end
    ref_mem[5] = 64'hABCD;
    tb_mem[5]  = 64'hABCD;

    repeat (2) @(posedge aclk);
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_txn", 64'(txn_count), 64'd0);
    check("rst_mem_vld", 64'(mm_tvalid), 64'd0);
    check("rst_req_rdy", 64'(req_tready), 64'd0);
    check("rst_mem_rdy", 64'(ms_tready), 64'd0);
    check("rst_rsp_vld", 64'(rsp_tvalid), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    sync();

    // Single read from requester 1.
    g0 = grant_log.size();
    send(1, 1'b0, 8'h05, 64'd0, 0);
    wait_idle();
    check("s1_grant", 64'(grant_log[g0]), 64'd1);
    check("s1_txn", 64'(txn_count), 64'd1);

    // Write then read-back through different requesters.
    sync();
    g0 = grant_log.size();
    send(2, 1'b1, 8'h10, 64'h1234, 0);
    send(0, 1'b0, 8'h10, 64'd0, 0);
    wait_idle();
    check("s2_grant_a", 64'(grant_log[g0]), 64'd2);
    check("s2_grant_b", 64'(grant_log[g0+1]), 64'd0);
    check("s2_txn", 64'(txn_count), 64'(pkts_done_exp));

    // All four continuously valid from a fresh rr pointer.
    do_reset();
    g0 = grant_log.size();
    fork
      send_reads(0, 3);
      send_reads(1, 3);
      send_reads(2, 3);
      send_reads(3, 3);
    join
    wait_idle();
    for (int k = 0; k < 12; k++) check("s3_grant_order", 64'(grant_log[g0+k]), 64'(k % 4));
    check("s3_txn", 64'(txn_count), 64'd12);

    // Response backpressure from requester 3 while requester 0 waits.
    sync();
    rsp_rdy[3] = 1'b0;
    g0 = grant_log.size();
    fork send(3, 1'b0, 8'h33, 64'd0, 0); join_none
    t = 0;
    while (!rsp_tvalid[3] && t < 500) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 500) fail("s4_rsp_wait");
    fork send(0, 1'b0, 8'h03, 64'd0, 0); join_none
    repeat (10) begin
      @(negedge aclk);
      check("s4_mem_rdy_low", 64'(ms_tready), 64'd0);
      check("s4_rsp_stable", rsp_tdata, ref_mem[8'h33]);
      check("s4_grant_held", 64'(grant_id), 64'd3);
    end
    sync();
    rsp_rdy[3] = 1'b1;
    wait_idle();
    check("s4_grant_a", 64'(grant_log[g0]), 64'd3);
    check("s4_grant_b", 64'(grant_log[g0+1]), 64'd0);
    check("s4_txn", 64'(txn_count), 64'(pkts_done_exp));

    // Mid-packet stall by requester 1 while requester 2 is valid.
    sync();
    g0 = grant_log.size();
    fork send(1, 1'b0, 8'h21, 64'd0, 5); join_none
    t = 0;
    while (!(busy && grant_id == 2'd1) && t < 500) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 500) fail("s5_grant_wait");
    sync();
    fork send(2, 1'b0, 8'h22, 64'd0, 0); join_none
    wait_idle();
    check("s5_grant_a", 64'(grant_log[g0]), 64'd1);
    check("s5_grant_b", 64'(grant_log[g0+1]), 64'd2);

    // Reset in the middle of a write packet from requester 2.
    sync();
    rq_dat[2] = 64'd1;
    rq_lst[2] = 1'b0;
    rq_vld[2] = 1'b1;
    hs = 1'b0;
    t  = 0;
    while (!hs && t < 500) begin
      @(negedge aclk);
      hs = req_tready[2];
      @(posedge aclk);
      #1;
      t++;
    end
    if (!hs) fail("s6_cmd_accept");
    rq_dat[2] = 64'h50;
    #1;
    check("s6_fwd_vld", 64'(mm_tvalid), 64'd1);
    check("s6_fwd_busy", 64'(busy), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("s6_rst_mem_vld", 64'(mm_tvalid), 64'd0);
    check("s6_rst_req_rdy", 64'(req_tready), 64'd0);
    check("s6_rst_mem_rdy", 64'(ms_tready), 64'd0);
    check("s6_rst_rsp_vld", 64'(rsp_tvalid), 64'd0);
    check("s6_rst_busy", 64'(busy), 64'd0);
    check("s6_rst_txn", 64'(txn_count), 64'd0);
    check("s6_rst_grant", 64'(grant_id), 64'd0);
    rq_vld[2] = 1'b0;
    pkts_done_exp = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    sync();
    g0 = grant_log.size();
    fork
      send(3, 1'b0, 8'h53, 64'd0, 0);
      send(1, 1'b0, 8'h51, 64'd0, 0);
    join
    wait_idle();
    check("s6_first_grant", 64'(grant_log[g0]), 64'd1);
    check("s6_second_grant", 64'(grant_log[g0+1]), 64'd3);
    check("s6_txn", 64'(txn_count), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
